// File: rtl/costas_loop_filter.sv
// -----------------------------------------------------------------------------
// costas_loop_filter
//
// Back half of the Costas loop. Integrates-and-dumps the I/Q mixer products
// over DUMP_LEN samples, forms the decision-directed phase error sign(I)*Q,
// runs it through a proportional-integral loop filter and writes the resulting
// frequency word into the NCO through its we/reg_select/data/rfd interface.
//
// Optional feature: define COSTAS_LOCK_DETECT_EN to add the 'lock' output.
// It is driven by a saturating 4-bit counter that counts consecutive dumps with
// |I| >= 4*|Q|.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   i_prod      signed din*cosine product
//   q_prod      signed din*sine product
//   prod_valid  qualifies i_prod/q_prod for one cycle
//   enable      loop closed when high; low clears the loop state
//   nco_rfd     NCO ready for data
//   nco_we      NCO write enable, held until nco_rfd accepts the write
//   nco_reg_se  NCO register select, always 0 (frequency register)
//   nco_data    frequency word presented to the NCO
//   freq_word   last computed frequency word
//   phase_err   last signed phase error
//   err_valid   one-cycle pulse when phase_err updates
//   overrun     sticky: a dump arrived while a previous one was in flight
//   lock        (COSTAS_LOCK_DETECT_EN only) carrier lock indication
// -----------------------------------------------------------------------------
module costas_loop_filter #(
  parameter int          DUMP_LEN  = 64,
  parameter int          LOG2_DUMP = 6,
  parameter int          KP_SHL    = 12,
  parameter int          KI_SHL    = 4,
  parameter logic [31:0] FREQ_INIT = 32'h2000_0000,
  parameter logic [31:0] INTEG_LIM = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_prod,
  input  logic [15:0] q_prod,
  input  logic        prod_valid,
  input  logic        enable,
  input  logic        nco_rfd,
  output logic        nco_we,
  output logic        nco_reg_se,
  output logic [31:0] nco_data,
  output logic [31:0] freq_word,
  output logic [15:0] phase_err,
  output logic        err_valid,
  output logic        overrun
`ifdef COSTAS_LOCK_DETECT_EN
  ,
  output logic        lock
`endif
);

  localparam int ACC_W = 16 + LOG2_DUMP;
  localparam logic signed [32:0] LIM_P = $signed({1'b0, INTEG_LIM});
  localparam logic signed [32:0] LIM_N = -LIM_P;

  typedef enum logic [1:0] {S_IDLE, S_PD, S_LF, S_WR} state_t;

  state_t state, state_next;

  logic [ACC_W-1:0]      acc_i, acc_q;
  logic [ACC_W-1:0]      acc_i_sum, acc_q_sum;
  logic [LOG2_DUMP-1:0]  cnt;
  logic                  dump_now;
  logic                  dump_q;
  logic                  sum_i_neg;
  logic [15:0]           sum_q;
  logic [15:0]           pd_err;
  logic signed [31:0]    integ;
  logic signed [31:0]    e_ext, ki_term, kp_term;
  logic signed [32:0]    integ_sum;
  logic signed [31:0]    integ_new;
  logic [31:0]           freq_new;

  assign nco_reg_se = 1'b0;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    acc_i_sum = acc_i + {{LOG2_DUMP{i_prod[15]}}, i_prod};
    acc_q_sum = acc_q + {{LOG2_DUMP{q_prod[15]}}, q_prod};
    dump_now  = enable && prod_valid && (cnt == LOG2_DUMP'(DUMP_LEN - 1));

    // sign(I)*Q; I == 0 is treated as positive, and -(-32768) saturates.
    pd_err = sum_q;
    if (sum_i_neg) begin
      pd_err = (sum_q == 16'h8000) ? 16'h7FFF : (16'h0000 - sum_q);
    end

    e_ext     = $signed({{16{phase_err[15]}}, phase_err});
    ki_term   = e_ext <<< KI_SHL;
    kp_term   = e_ext <<< KP_SHL;
    integ_sum = $signed({integ[31], integ}) + $signed({ki_term[31], ki_term});

    integ_new = integ_sum[31:0];
    if (integ_sum > LIM_P) begin
      integ_new = LIM_P[31:0];
    end else if (integ_sum < LIM_N) begin
      integ_new = LIM_N[31:0];
    end

    freq_new = FREQ_INIT + kp_term + integ_new;
  end

  // ---------------------------------------------------------------------------
  // FSM: the dump is registered (dump_q) before the FSM sees it, so the write
  // reaches the NCO three cycles after the dump sample.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (dump_q) state_next = S_PD;
      S_PD:    state_next = S_LF;
      S_LF:    state_next = S_WR;
      S_WR:    if (nco_rfd) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (!enable) state_next = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

`ifdef COSTAS_LOCK_DETECT_EN
  logic [15:0] sum_i;
  logic [3:0]  lock_cnt;
  logic [16:0] abs_i, abs_q;
  logic        lock_hit;

  always_comb begin
    abs_i    = sum_i[15] ? (17'd0 - {sum_i[15], sum_i}) : {1'b0, sum_i};
    abs_q    = sum_q[15] ? (17'd0 - {sum_q[15], sum_q}) : {1'b0, sum_q};
    lock_hit = ({2'b00, abs_i} >= {abs_q, 2'b00});
  end

  assign lock = (lock_cnt == 4'hF);
`endif

  // ---------------------------------------------------------------------------
  // Accumulators, phase detector and loop filter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_i     <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      dump_q    <= 1'b0;
      sum_i_neg <= 1'b0;
      sum_q     <= '0;
      integ     <= '0;
      freq_word <= FREQ_INIT;
      nco_data  <= FREQ_INIT;
      nco_we    <= 1'b0;
      phase_err <= '0;
      err_valid <= 1'b0;
      overrun   <= 1'b0;
`ifdef COSTAS_LOCK_DETECT_EN
      sum_i     <= '0;
      lock_cnt  <= '0;
`endif
    end else if (!enable) begin
      // Open loop: drop everything in flight and return to the nominal word.
      acc_i     <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      dump_q    <= 1'b0;
      integ     <= '0;
      freq_word <= FREQ_INIT;
      nco_data  <= FREQ_INIT;
      nco_we    <= 1'b0;
      err_valid <= 1'b0;
`ifdef COSTAS_LOCK_DETECT_EN
      lock_cnt  <= '0;
`endif
    end else begin
      err_valid <= 1'b0;
      dump_q    <= dump_now;

      // Samples keep accumulating whatever the FSM is doing.
      if (prod_valid) begin
        if (dump_now) begin
          acc_i     <= '0;
          acc_q     <= '0;
          cnt       <= '0;
          sum_i_neg <= acc_i_sum[ACC_W-1];
          sum_q     <= acc_q_sum[ACC_W-1:LOG2_DUMP];
`ifdef COSTAS_LOCK_DETECT_EN
          sum_i     <= acc_i_sum[ACC_W-1:LOG2_DUMP];
`endif
        end else begin
          acc_i <= acc_i_sum;
          acc_q <= acc_q_sum;
          cnt   <= cnt + 1'b1;
        end
      end

      if (dump_q && (state != S_IDLE)) overrun <= 1'b1;

      // Entering S_PD: phase error and its strobe are valid during S_PD.
      if ((state == S_IDLE) && dump_q) begin
        phase_err <= pd_err;
        err_valid <= 1'b1;
`ifdef COSTAS_LOCK_DETECT_EN
        if (!lock_hit)              lock_cnt <= '0;
        else if (lock_cnt != 4'hF)  lock_cnt <= lock_cnt + 1'b1;
`endif
      end

      if (state == S_LF) begin
        integ     <= integ_new;
        freq_word <= freq_new;
        nco_data  <= freq_new;
      end

      nco_we <= (state_next == S_WR);
    end
  end

endmodule

// File: tb/tb_costas_loop_filter.sv
// -----------------------------------------------------------------------------
// tb_costas_loop_filter
//
// Directed bench for costas_loop_filter: reset state, zero/positive/negative
// phase error, saturation of the negated error, write latency, NCO back-pressure
// with overrun, enable drop mid-dump and reset during a pending write.
// -----------------------------------------------------------------------------
module tb_costas_loop_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_prod, q_prod;
  logic        prod_valid, enable, nco_rfd;
  logic        nco_we, nco_reg_se, err_valid, overrun;
  logic [31:0] nco_data, freq_word;
  logic [15:0] phase_err;
`ifdef COSTAS_LOCK_DETECT_EN
  logic        lock;
`endif

  int tests = 0;
  int fails = 0;

  // Observation results
  int          n_err, n_we, first_we;
  logic [31:0] we_data;
  logic [15:0] err_seen;
  int          bad;

  always #5 clk = ~clk;

  costas_loop_filter dut (
    .clk        (clk),
    .rst        (rst),
    .i_prod     (i_prod),
    .q_prod     (q_prod),
    .prod_valid (prod_valid),
    .enable     (enable),
    .nco_rfd    (nco_rfd),
    .nco_we     (nco_we),
    .nco_reg_se (nco_reg_se),
    .nco_data   (nco_data),
    .freq_word  (freq_word),
    .phase_err  (phase_err),
    .err_valid  (err_valid),
    .overrun    (overrun)
`ifdef COSTAS_LOCK_DETECT_EN
    ,
    .lock       (lock)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive n valid samples on consecutive cycles; returns at the negedge that
  // follows the last sample's sampling edge.
  task automatic drive(input logic [15:0] iv, input logic [15:0] qv, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      prod_valid = 1'b1;
      i_prod     = iv;
      q_prod     = qv;
    end
    @(negedge clk);
    prod_valid = 1'b0;
  endtask

  // Watch outputs for a fixed number of cycles; index 0 is the current negedge.
  task automatic observe(input int cycles);
    n_err    = 0;
    n_we     = 0;
    first_we = -1;
    for (int k = 0; k < cycles; k++) begin
      if (k > 0) @(negedge clk);
      if (err_valid === 1'b1) begin
        n_err++;
        err_seen = phase_err;
      end
      if (nco_we === 1'b1) begin
        if (first_we < 0) begin
          first_we = k;
          we_data  = nco_data;
        end
        n_we++;
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    nco_rfd    = 1'b0;
    prod_valid = 1'b0;
    i_prod     = '0;
    q_prod     = '0;

    // Reset
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_nco_we",     32'(nco_we),     32'h0);
    check("rst_freq_word",  freq_word,       32'h2000_0000);
    check("rst_nco_data",   nco_data,        32'h2000_0000);
    check("rst_phase_err",  32'(phase_err),  32'h0);
    check("rst_overrun",    32'(overrun),    32'h0);
    check("rst_err_valid",  32'(err_valid),  32'h0);
    check("rst_reg_se",     32'(nco_reg_se), 32'h0);
    rst     = 1'b0;
    enable  = 1'b1;
    nco_rfd = 1'b1;

    // Zero phase error: I = 1000, Q = 0
    drive(16'd1000, 16'd0, 64);
    observe(8);
    check("zero_err_cnt",   32'(n_err),    32'd1);
    check("zero_err_val",   32'(err_seen), 32'h0);
    check("zero_we_cnt",    32'(n_we),     32'd1);
    check("zero_we_lat",    32'(first_we), 32'd3);
    check("zero_we_data",   we_data,       32'h2000_0000);

    // Positive error, two dumps: integrator builds up
    drive(16'd1000, 16'd256, 64);
    observe(8);
    check("pos1_err",       32'(err_seen), 32'h0000_0100);
    check("pos1_we_cnt",    32'(n_we),     32'd1);
    check("pos1_data",      we_data,       32'h2010_1000);
    drive(16'd1000, 16'd256, 64);
    observe(8);
    check("pos2_err",       32'(err_seen), 32'h0000_0100);
    check("pos2_data",      we_data,       32'h2010_2000);
    check("pos2_freq_word", freq_word,     32'h2010_2000);

    // Enable low clears the integrator and restores the nominal word
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("dis_freq_word",  freq_word,     32'h2000_0000);
    check("dis_nco_data",   nco_data,      32'h2000_0000);
    enable = 1'b1;

    // Negative I flips the error sign
    drive(16'hFC18, 16'd256, 64);
    observe(8);
    check("neg_err",        32'(err_seen), 32'h0000_FF00);
    check("neg_data",       we_data,       32'h1FEF_F000);

    // Negating -32768 saturates to 32767 (integrator now at -0x1000)
    drive(16'hFC18, 16'h8000, 64);
    observe(8);
    check("sat_err",        32'(err_seen), 32'h0000_7FFF);
    check("sat_data",       we_data,       32'h2807_DFF0);

    // Back-pressure: rfd low for 200 cycles, second dump dropped
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable  = 1'b1;
    nco_rfd = 1'b0;
    drive(16'd1000, 16'd256, 64);
    repeat (3) @(negedge clk);
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      if (!(nco_we === 1'b1 && nco_data === 32'h2010_1000)) bad++;
      prod_valid = (k < 64);
      i_prod     = 16'd1000;
      q_prod     = 16'd256;
      @(negedge clk);
    end
    prod_valid = 1'b0;
    check("hold_we_data",   32'(bad),      32'd0);
    check("hold_overrun",   32'(overrun),  32'h1);
    check("hold_freq_word", freq_word,     32'h2010_1000);
    nco_rfd = 1'b1;
    observe(6);
    check("release_we_cnt", 32'(n_we),     32'd1);
    check("release_no_err", 32'(n_err),    32'd0);

    // Enable dropped at sample 30: nothing computed, count restarts
    drive(16'd1000, 16'd256, 30);
    enable = 1'b0;
    observe(4);
    check("drop_err_cnt",   32'(n_err),    32'd0);
    check("drop_we_cnt",    32'(n_we),     32'd0);
    check("drop_freq_word", freq_word,     32'h2000_0000);
    enable = 1'b1;
    drive(16'd1000, 16'd256, 63);
    observe(8);
    check("re63_err_cnt",   32'(n_err),    32'd0);
    check("re63_we_cnt",    32'(n_we),     32'd0);
    drive(16'd1000, 16'd256, 1);
    observe(8);
    check("re64_err_cnt",   32'(n_err),    32'd1);
    check("re64_err",       32'(err_seen), 32'h0000_0100);
    check("re64_we_lat",    32'(first_we), 32'd3);
    check("re64_data",      we_data,       32'h2010_1000);

    // Reset while a write is pending
    nco_rfd = 1'b0;
    drive(16'd1000, 16'd256, 64);
    observe(5);
    check("prerst_we",      32'(nco_we),   32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_we",      32'(nco_we),   32'h0);
    check("midrst_overrun", 32'(overrun),  32'h0);
    check("midrst_freq",    freq_word,     32'h2000_0000);
    check("midrst_data",    nco_data,      32'h2000_0000);
    check("midrst_err",     32'(phase_err), 32'h0);
    rst     = 1'b0;
    nco_rfd = 1'b1;
    observe(4);
    check("postrst_we_cnt", 32'(n_we),     32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/costas_loop_filter.md
Name: costas_loop_filter

Overview:
- Downstream stage of the Costas loop. Consumes the I/Q mixer products (din*cosine, din*sine) and integrates-and-dumps them over DUMP_LEN samples.
- Computes a decision-directed phase error, sign(I)*Q, and runs it through a proportional-integral loop filter.
- Writes the resulting 32-bit frequency word back into the NCO through its we/reg_select/data/rfd programming interface. This closes the loop.

Parameters:
- DUMP_LEN, 64: samples per integrate-and-dump; power of two, >= 8.
- LOG2_DUMP, 6: log2(DUMP_LEN).
- KP_SHL, 12: proportional gain, as a left shift of the error.
- KI_SHL, 4: integral gain, as a left shift of the error.
- FREQ_INIT, 32'h2000_0000: nominal NCO frequency word.
- INTEG_LIM, 32'h4000_0000: integrator saturation magnitude.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_prod  in  16  signed din*cosine product.
- q_prod  in  16  signed din*sine product.
- prod_valid  in  1  qualifies i_prod/q_prod for one cycle.
- enable  in  1  loop closed when high.
- nco_rfd  in  1  NCO ready for data.
- nco_we  out  1  NCO write enable.
- nco_reg_se  out  1  NCO register select; constant 0 (frequency register).
- nco_data  out  32  frequency word presented to the NCO.
- freq_word  out  32  last computed frequency word.
- phase_err  out  16  last signed phase error.
- err_valid  out  1  one-cycle pulse when phase_err updates.
- overrun  out  1  sticky: a dump was dropped.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - freq_word = nco_data = FREQ_INIT.
  - All other outputs 0.
  - Accumulators, sample count and integrator 0.
  - FSM in S_IDLE.
- Accumulate:
  - On prod_valid, add sign-extended products into acc_i and acc_q (each 16+LOG2_DUMP bits) and increment cnt.
  - On the valid sample with cnt == DUMP_LEN-1, dump (that sample included):
    - sum_i = (acc_i + i_prod) >>> LOG2_DUMP, truncated to 16 bits; sum_q likewise.
    - Accumulators and cnt restart at 0 next cycle.
- FSM states: S_IDLE, S_PD, S_LF, S_WR.
  - S_IDLE -> S_PD on a dump.
  - S_PD: phase_err = (sum_i < 0) ? -sum_q : sum_q. sum_i == 0 counts as positive. Negating -32768 saturates to 32767. err_valid pulses this cycle; go to S_LF.
  - S_LF:
    - e = sext32(phase_err).
    - integ = sat(integ + (e <<< KI_SHL), ±INTEG_LIM).
    - freq_word = FREQ_INIT + (e <<< KP_SHL) + integ_new, modulo 2^32.
    - nco_data <= freq_word; go to S_WR.
  - S_WR: hold nco_we = 1 and nco_data stable until a cycle with nco_rfd = 1. The write completes in that cycle; nco_we deasserts next cycle; go to S_IDLE.
- Latency: dump-sample edge to nco_we high is 3 cycles when nco_rfd is already high.
- Dump while FSM is not in S_IDLE: the dump is discarded, overrun is set (cleared only by rst), and accumulation continues.
- enable low, takes effect next cycle:
  - Accumulators, cnt and integ cleared.
  - FSM forced to S_IDLE; any pending write is abandoned (nco_we = 0).
  - freq_word = nco_data = FREQ_INIT.
  - prod_valid ignored.
- enable rising: accumulation starts fresh from sample 0.
- rst mid-write: nco_we drops next cycle; all state returns to reset values.
- prod_valid during S_PD, S_LF or S_WR is still accumulated; no samples are lost.

Optional Feature:
- Macro: COSTAS_LOCK_DETECT_EN.
- Defined: adds output lock (1 bit, reset 0).
  - At each S_PD, a saturating 4-bit counter increments if |sum_i| >= 4*|sum_q|; otherwise it clears.
  - lock = 1 while counter == 15.
  - lock is cleared by enable low.
- Undefined: no lock port and no counter logic.

Test Plan:
- Reset: assert rst 2 cycles -> nco_we = 0, freq_word = 0x2000_0000, phase_err = 0, overrun = 0.
- enable = 1, nco_rfd = 1, i_prod = 1000, q_prod = 0 for 64 valids -> single err_valid with phase_err = 0; nco_we for 1 cycle, 3 cycles after the last sample, with nco_data = 0x2000_0000.
- i_prod = 1000, q_prod = 256 for 2 dumps -> phase_err = 256; first write 0x2010_1000, second write 0x2010_2000.
- i_prod = -1000, q_prod = 256 for 1 dump -> phase_err = -256, nco_data = 0x1FEF_F000. With q_prod = -32768, i_prod = -1000 -> phase_err = 32767.
- nco_rfd low for 200 cycles after a dump -> nco_we held high with stable nco_data; the next dump is dropped and overrun = 1; raising nco_rfd gives exactly one write.
- enable dropped at sample 30 of a dump -> no err_valid, no write, freq_word = 0x2000_0000; after re-enable, the first dump needs a full 64 new samples.
